// File: rtl/sha1_pad_pkg.sv
// Shared types and constants for the SHA-1 message padder.
package sha1_pad_pkg;

  typedef enum logic [2:0] {
    S_DATA,
    S_PAD,
    S_FILL,
    S_ZERO,
    S_LEN_HI,
    S_LEN_LO
  } pad_state_e;

  localparam logic [7:0] PAD_BYTE        = 8'h80;
  localparam logic [3:0] LEN_HI_IDX      = 4'd14;
  localparam logic [3:0] LEN_LO_IDX      = 4'd15;
  localparam int         WORDS_PER_BLOCK = 16;
  localparam logic [3:0] LAST_ZERO_IDX   = LEN_HI_IDX - 4'd1;

endpackage

// File: rtl/sha1_word_packer.sv
// Byte-to-word assembly buffer: up to three pending bytes plus the 0x80-terminated flush word.
module sha1_word_packer
  import sha1_pad_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        flush,
  input  logic [7:0]  byte_in,
  output logic [1:0]  pos,
  output logic [31:0] full_word,
  output logic [31:0] pad_word
);

  // Bytes shift in from the right, so the newest byte is always in [7:0].
  logic [23:0] word_buf_q;
  logic [1:0]  pos_q;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      word_buf_q <= '0;
      pos_q      <= '0;
    end else if (push) begin
      word_buf_q <= {word_buf_q[15:0], byte_in};
      pos_q      <= pos_q + 2'd1;
    end
  end

  assign pos       = pos_q;
  assign full_word = {word_buf_q, byte_in};

  always_comb begin
    pad_word = {PAD_BYTE, 24'h0};
    case (pos_q)
      2'd0:    pad_word = {PAD_BYTE, 24'h0};
      2'd1:    pad_word = {word_buf_q[7:0], PAD_BYTE, 16'h0};
      2'd2:    pad_word = {word_buf_q[15:0], PAD_BYTE, 8'h0};
      default: pad_word = {word_buf_q, PAD_BYTE};
    endcase
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: byte stream in, padded 16-word blocks out.
// Valid/ready: a beat transfers on a rising edge where valid && ready; a held word stays stable until taken.
module sha1_msg_padder
  import sha1_pad_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_word_idx,
  output logic        out_block_end,
  output logic        out_msg_end,
  output logic        busy
);

  pad_state_e  state_q, state_d;
  logic [60:0] len_bytes_q;
  logic [3:0]  next_idx_q;
  logic [63:0] bit_len;
  logic [1:0]  pos;
  logic [31:0] full_word, pad_word;
  logic        accept, push, can_load;
  logic        load_en, load_msg_end, flush;
  logic [31:0] load_data;

  assign bit_len  = {len_bytes_q, 3'b000};
  assign can_load = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !(in_last && in_empty);

  sha1_word_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .flush     (flush),
    .byte_in   (in_data),
    .pos       (pos),
    .full_word (full_word),
    .pad_word  (pad_word)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_DATA;
    else          state_q <= state_d;
  end

  // A pad word at index 15 already closes its block, so the extra block starts directly with zeros.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DATA:   if (accept && in_last) state_d = S_PAD;
      S_PAD:    if (can_load) begin
                  if (next_idx_q < LAST_ZERO_IDX || next_idx_q == LEN_LO_IDX) state_d = S_ZERO;
                  else if (next_idx_q == LAST_ZERO_IDX)                        state_d = S_LEN_HI;
                  else                                                         state_d = S_FILL;
                end
      S_FILL:   if (can_load && next_idx_q == LEN_LO_IDX)    state_d = S_ZERO;
      S_ZERO:   if (can_load && next_idx_q == LAST_ZERO_IDX) state_d = S_LEN_HI;
      S_LEN_HI: if (can_load) state_d = S_LEN_LO;
      S_LEN_LO: if (can_load) state_d = S_DATA;
      default:  state_d = S_DATA;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    load_en      = 1'b0;
    load_data    = '0;
    load_msg_end = 1'b0;
    flush        = 1'b0;
    case (state_q)
      S_DATA: begin
        in_ready  = reset_n && !(pos == 2'd3 && !can_load);
        load_en   = push && pos == 2'd3;
        load_data = full_word;
      end
      S_PAD: begin
        load_en   = can_load;
        load_data = pad_word;
        flush     = can_load;
      end
      S_FILL, S_ZERO: load_en = can_load;
      S_LEN_HI: begin
        load_en   = can_load;
        load_data = bit_len[63:32];
      end
      S_LEN_LO: begin
        load_en      = can_load;
        load_data    = bit_len[31:0];
        load_msg_end = 1'b1;
        flush        = can_load;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_bytes_q   <= '0;
      next_idx_q    <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_word_idx  <= '0;
      out_block_end <= 1'b0;
      out_msg_end   <= 1'b0;
    end else begin
      if (state_q == S_LEN_LO && load_en) len_bytes_q <= '0;
      else if (push)                      len_bytes_q <= len_bytes_q + 61'd1;
      if (load_en) begin
        out_valid     <= 1'b1;
        out_data      <= load_data;
        out_word_idx  <= next_idx_q;
        out_block_end <= (next_idx_q == 4'(WORDS_PER_BLOCK - 1));
        out_msg_end   <= load_msg_end;
        next_idx_q    <= next_idx_q + 4'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // The length word still waiting in the output register counts as pending padding.
  assign busy = (state_q != S_DATA) || (len_bytes_q != '0) || (out_valid && out_msg_end);

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Bench for sha1_msg_padder: length table, hand-written corner sequences, randomized messages vs a padding model.
module tb_sha1_msg_padder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_empty;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_word_idx;
  logic        out_block_end;
  logic        out_msg_end;
  logic        busy;

  sha1_msg_padder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_empty      (in_empty),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_word_idx  (out_word_idx),
    .out_block_end (out_block_end),
    .out_msg_end   (out_msg_end),
    .busy          (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // {msg_end, block_end, idx, data}
  logic [37:0] exp_q[$];
  logic [7:0]  msg_q[$];

  int          words_seen, block_end_seen, msg_end_seen;
  logic [31:0] len_lo_seen;
  logic        stall_mode, gap_mode;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Padding as a byte array: msg, 0x80, zeros up to 56 mod 64, 64-bit big-endian bit length.
  task automatic model_push();
    logic [7:0]  b[$];
    logic [63:0] bits;
    int          nw;
    logic [3:0]  idx;
    b = msg_q;
    bits = 64'(msg_q.size()) * 64'd8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int k = 7; k >= 0; k--) b.push_back(bits[8*k +: 8]);
    nw = b.size() / 4;
    for (int w = 0; w < nw; w++) begin
      idx = 4'(w % 16);
      exp_q.push_back({(w == nw - 1), (idx == 4'd15), idx,
                       b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
    end
  endtask

  // ---------------- output ready generator ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_mode ? ($urandom_range(0, 99) < 55) : 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic        stalled_prev;
  logic [37:0] held;

  initial begin
    stalled_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid) begin
        if (stalled_prev)
          check("stall_stable", {26'h0, out_msg_end, out_block_end, out_word_idx, out_data}, {26'h0, held});
        if (out_ready) begin
          words_seen++;
          if (out_block_end) block_end_seen++;
          if (out_msg_end) begin
            msg_end_seen++;
            len_lo_seen = out_data;
          end
          if (exp_q.size() == 0) begin
            vectors++;
            fails++;
            $display("FAIL unexpected_word: got %0h, expected none", out_data);
          end else begin
            check("out_word", {26'h0, out_msg_end, out_block_end, out_word_idx, out_data},
                  {26'h0, exp_q.pop_front()});
          end
        end
      end
      stalled_prev = reset_n && out_valid && !out_ready;
      held = {out_msg_end, out_block_end, out_word_idx, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty, input int acc);
    int   budget;
    logic rdy, exp_rdy;
    budget = 0;
    if (gap_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_empty = empty;
    forever begin
      @(negedge clk);
      rdy     = in_ready;
      exp_rdy = !((acc % 4) == 3 && out_valid && !out_ready);
      check("in_ready", {63'h0, rdy}, {63'h0, exp_rdy});
      @(posedge clk);
      #1;
      if (rdy) break;
      budget++;
      if (budget > 200) begin
        check("in_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    check("idle_after_msg", {62'h0, busy, out_valid}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Sends msg_q; the end marker rides on the last byte or on a separate empty beat.
  task automatic send_msg_q(input logic tail_empty);
    int n;
    n = msg_q.size();
    words_seen = 0;
    block_end_seen = 0;
    msg_end_seen = 0;
    len_lo_seen = 32'hdead_beef;
    if (n == 0) begin
      send_beat(8'($urandom), 1'b1, 1'b1, 0);
    end else begin
      for (int i = 0; i < n; i++) send_beat(msg_q[i], (i == n - 1) && !tail_empty, 1'b0, i);
      if (tail_empty) send_beat(8'($urandom), 1'b1, 1'b1, n);
    end
    wait_drain();
  endtask

  task automatic random_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    model_push();
  endtask

  typedef struct {
    int          len;
    int          words;
    logic [31:0] len_lo;
  } vec_t;

  vec_t tbl[8];

  // ---------------- main sequence ----------------
  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_last    = 1'b0;
    in_empty   = 1'b0;
    out_ready  = 1'b1;
    stall_mode = 1'b0;
    gap_mode   = 1'b0;

    tbl[0] = '{0,   16, 32'h0000_0000};
    tbl[1] = '{3,   16, 32'h0000_0018};
    tbl[2] = '{52,  16, 32'h0000_01A0};
    tbl[3] = '{55,  16, 32'h0000_01B8};
    tbl[4] = '{56,  32, 32'h0000_01C0};
    tbl[5] = '{63,  32, 32'h0000_01F8};
    tbl[6] = '{64,  32, 32'h0000_0200};
    tbl[7] = '{120, 48, 32'h0000_03C0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {out_valid, out_data, out_word_idx, out_block_end, out_msg_end, busy, in_ready},
          64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {62'h0, in_ready, busy}, 64'd2);
    @(posedge clk);
    #1;

    // "abc" against hand-written constants
    msg_q = '{8'h61, 8'h62, 8'h63};
    exp_q.push_back({2'b00, 4'd0, 32'h6162_6380});
    for (int i = 1; i < 15; i++) exp_q.push_back({1'b0, 1'b0, 4'(i), 32'h0});
    exp_q.push_back({2'b11, 4'd15, 32'h0000_0018});
    send_msg_q(1'b0);
    check("abc_msg_end_count", 64'(msg_end_seen), 64'd1);

    // empty message against hand-written constants
    msg_q.delete();
    exp_q.push_back({2'b00, 4'd0, 32'h8000_0000});
    for (int i = 1; i < 15; i++) exp_q.push_back({1'b0, 1'b0, 4'(i), 32'h0});
    exp_q.push_back({2'b11, 4'd15, 32'h0});
    send_msg_q(1'b0);

    // length table
    for (int t = 0; t < 8; t++) begin
      random_msg(tbl[t].len);
      send_msg_q(1'b0);
      check($sformatf("tbl%0d_words", tbl[t].len), 64'(words_seen), 64'(tbl[t].words));
      check($sformatf("tbl%0d_len_lo", tbl[t].len), {32'h0, len_lo_seen}, {32'h0, tbl[t].len_lo});
      check($sformatf("tbl%0d_block_ends", tbl[t].len), 64'(block_end_seen), 64'(tbl[t].words / 16));
      check($sformatf("tbl%0d_msg_ends", tbl[t].len), 64'(msg_end_seen), 64'd1);
    end

    // 64 bytes with gaps on both sides
    stall_mode = 1'b1;
    gap_mode   = 1'b1;
    random_msg(64);
    send_msg_q(1'b0);
    check("stall64_len_lo", {32'h0, len_lo_seen}, 64'h200);
    check("stall64_words", 64'(words_seen), 64'd32);

    // randomized lengths, some ending on an empty beat
    for (int r = 0; r < 12; r++) begin
      random_msg($urandom_range(0, 130));
      send_msg_q(msg_q.size() != 0 && $urandom_range(0, 2) == 0);
    end
    stall_mode = 1'b0;
    gap_mode   = 1'b0;

    // reset after 20 bytes of a message
    msg_q.delete();
    for (int i = 0; i < 20; i++) msg_q.push_back(8'($urandom));
    for (int w = 0; w < 5; w++)
      exp_q.push_back({1'b0, 1'b0, 4'(w), msg_q[4*w], msg_q[4*w+1], msg_q[4*w+2], msg_q[4*w+3]});
    for (int i = 0; i < 20; i++) send_beat(msg_q[i], 1'b0, 1'b0, i);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("partial_words_out", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    reset_n = 1'b0;
    @(negedge clk);
    check("ready_low_in_reset", {63'h0, in_ready}, 64'd0);
    @(negedge clk);
    check("midmsg_reset_outputs",
          {out_valid, out_data, out_word_idx, out_block_end, out_msg_end, busy, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    exp_q.push_back({2'b00, 4'd0, 32'h6162_6380});
    for (int i = 1; i < 15; i++) exp_q.push_back({1'b0, 1'b0, 4'(i), 32'h0});
    exp_q.push_back({2'b11, 4'd15, 32'h0000_0018});
    send_msg_q(1'b0);
    check("abc_after_reset_words", 64'(words_seen), 64'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
